fpadd_align_stage: RTL and testbench
====================================

// Module: fpadd_align_stage
// PURPOSE
//  Registered upstream stage of the FP32 adder datapath: accepts raw IEEE-754 single operands a/b,
//  orders them by magnitude, decodes hidden bits/denormals, computes alignment shift, detects
//  special cases. Feeds the aligner/adder (large/small mantissa, signs, exponent, shift) through a
//  valid/ready interface with a 1-entry skid buffer so the stage never drops or duplicates operands.
// PARAMETERS
//  SHIFT_SAT  27            shift_n saturates here (>= mantissa+guard width: everything goes to sticky)
//  QNAN       32'h7FC00000  canonical quiet NaN driven on special_res
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   a/b valid
//  in_ready     out  1   stage can accept a/b this cycle
//  a            in   32  operand A (IEEE-754 single)
//  b            in   32  operand B
//  out_valid    out  1   outputs below valid
//  out_ready    in   1   downstream accepts this cycle
//  large_mant   out  24  {hidden, frac} of larger-magnitude operand
//  small_mant   out  24  {hidden, frac} of smaller-magnitude operand
//  large_sign   out  1   sign of larger operand
//  small_sign   out  1   sign of smaller operand
//  large_e      out  8   effective exponent of larger operand
//  shift_n      out  5   right-shift for small_mant, saturated to SHIFT_SAT
//  special      out  1   result is special_res; downstream bypasses arithmetic
//  special_res  out  32  final result when special=1, else 0
// BEHAVIOUR
//  Reset: out_valid=0, skid empty, in_ready=1, all data outputs 0. Reset mid-transfer discards both
//   entries; nothing emitted after rst_n rises until a new in_valid&&in_ready.
//  Handshake: accept when in_valid&&in_ready; emit when out_valid&&out_ready. Outputs stable while
//   out_valid&&!out_ready. in_ready = !skid_full (registered, no comb path from out_ready).
//  Latency 1 cycle accept->out_valid when output register empty or draining. Throughput 1/cycle.
//  Skid: accept while out reg full and !out_ready -> entry goes to skid, skid_full=1. Next
//   out_ready cycle: out reg <= skid, skid_full=0. Accept+emit same cycle: new entry goes
//   straight to out reg. Order strictly FIFO.
//  Ordering: compare a[30:0] vs b[30:0] unsigned (exp then frac). a>b -> large=a; b>a -> large=b;
//   equal -> large=a, small=b.
//  Decode: e==0 -> hidden=0, effective exp=1; else hidden=1, effective exp=e.
//  shift_n = min(eff_eL - eff_eS, SHIFT_SAT); difference computed at 8 bits, never negative.
//  Specials (priority order), special=1:
//   1) either exp=255 & frac!=0 -> QNAN
//   2) both inf, signs differ -> QNAN
//   3) either inf -> that inf (same-sign inf+inf -> that inf)
//   4) both zero (+/-) -> {a[31]&b[31], 31'b0}
//   5) exactly one zero -> other operand bit-exact (denormals included)
//   Else special=0, special_res=0. Datapath fields still driven from ordering when special=1.
//  All fields computed combinationally from a/b, captured at acceptance; no other state.
// TESTING
//  a=3F800000,b=40000000, out_ready=1 -> 1 cyc later large_mant=800000,large_e=80,small_mant=800000,shift_n=1,special=0
//  a=00000001,b=80000003 -> large=b: large_sign=1,large_mant=000003,large_e=01,small_mant=000001,shift_n=0
//  a=7F800000,b=FF800000 -> special=1,special_res=7FC00000; a=80000000,b=80000000 -> special_res=80000000
//  a=4B000000,b=33800000 -> shift_n=27 (saturated); a=7FA00000,b=any -> special_res=7FC00000
//  3 back-to-back ops, out_ready=0 for 3 cycles: in_ready drops after 2nd accept, 3rd held; release -> all 3 in order, none lost/duplicated
//  rst_n low while out_valid=1 & skid full -> out_valid=0,in_ready=1 async; no stale output after release

Source files
------------

// File: rtl/fpadd_align_stage.sv
// FP32 adder front end: orders a/b by magnitude, decodes hidden bits, computes the alignment shift, flags specials.
// Latency 1 cycle from acceptance to out_valid; throughput one operand pair per cycle.
// Backpressure: 1-entry skid buffer absorbs one pair while stalled; in_ready is registered (!skid_full).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready, a, b upstream handshake and raw IEEE-754 single operands
//   out_valid/out_ready     downstream handshake
//   large_*/small_*         mantissas {hidden,frac}, signs, effective exponent of larger operand
//   shift_n                 right shift for small_mant, saturated to SHIFT_SAT
//   special/special_res     result bypass for NaN/inf/zero cases
module fpadd_align_stage #(
    parameter logic [4:0]  SHIFT_SAT = 5'd27,
    parameter logic [31:0] QNAN      = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] large_mant,
    output logic [23:0] small_mant,
    output logic        large_sign,
    output logic        small_sign,
    output logic [7:0]  large_e,
    output logic [4:0]  shift_n,
    output logic        special,
    output logic [31:0] special_res
);

    // Packed field order: large_mant, small_mant, large_sign, small_sign, large_e, shift_n, special, special_res
    localparam int W = 24 + 24 + 1 + 1 + 8 + 5 + 1 + 32;

    logic [31:0]  w_large;
    logic [31:0]  w_small;
    logic [7:0]   w_eff_el;
    logic [7:0]   w_eff_es;
    logic [7:0]   w_ediff;
    logic [4:0]   w_shift;
    logic         w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic         w_special;
    logic [31:0]  w_special_res;
    logic [W-1:0] w_nxt;
    logic         w_accept;
    logic         w_load_ok;

    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         r_out_vld;
    logic         r_skid_full;

    // Magnitude ordering; ties keep a as the large operand.
    always_comb begin
        if (b[30:0] > a[30:0]) begin
            w_large = b;
            w_small = a;
        end else begin
            w_large = a;
            w_small = b;
        end
    end

    // Denormals use effective exponent 1 with hidden bit 0.
    assign w_eff_el = (w_large[30:23] == 8'd0) ? 8'd1 : w_large[30:23];
    assign w_eff_es = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
    // Ordering guarantees eff_el >= eff_es, so the 8-bit difference never wraps.
    assign w_ediff  = w_eff_el - w_eff_es;
    assign w_shift  = (w_ediff > {3'd0, SHIFT_SAT}) ? SHIFT_SAT : w_ediff[4:0];

    assign w_a_nan  = (&a[30:23]) && (|a[22:0]);
    assign w_b_nan  = (&b[30:23]) && (|b[22:0]);
    assign w_a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
    assign w_b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
    assign w_a_zero = (a[30:0] == 31'd0);
    assign w_b_zero = (b[30:0] == 31'd0);

    always_comb begin
        w_special     = 1'b1;
        w_special_res = 32'd0;
        if (w_a_nan || w_b_nan) begin
            w_special_res = QNAN;
        end else if (w_a_inf && w_b_inf && (a[31] != b[31])) begin
            w_special_res = QNAN;
        end else if (w_a_inf) begin
            w_special_res = a;
        end else if (w_b_inf) begin
            w_special_res = b;
        end else if (w_a_zero && w_b_zero) begin
            w_special_res = {a[31] & b[31], 31'd0};
        end else if (w_a_zero) begin
            w_special_res = b;
        end else if (w_b_zero) begin
            w_special_res = a;
        end else begin
            w_special     = 1'b0;
        end
    end

    assign w_nxt = {(w_large[30:23] != 8'd0), w_large[22:0],
                    (w_small[30:23] != 8'd0), w_small[22:0],
                    w_large[31], w_small[31], w_eff_el, w_shift,
                    w_special, w_special_res};

    assign w_accept  = in_valid && !r_skid_full;
    // Output register may take new content when empty or being drained this cycle.
    assign w_load_ok = !r_out_vld || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_skid      <= '0;
            r_out_vld   <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_load_ok) begin
            if (r_skid_full) begin
                // Skid holds the oldest pending entry; in_ready is low so no accept this cycle.
                r_out       <= r_skid;
                r_out_vld   <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_nxt;
                r_out_vld   <= 1'b1;
            end else begin
                r_out_vld   <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid      <= w_nxt;
            r_skid_full <= 1'b1;
        end
    end

    assign in_ready  = !r_skid_full;
    assign out_valid = r_out_vld;
    assign {large_mant, small_mant, large_sign, small_sign, large_e, shift_n, special, special_res} = r_out;

endmodule

// File: tb/tb_fpadd_align_stage.sv
module tb_fpadd_align_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] large_mant;
    logic [23:0] small_mant;
    logic        large_sign;
    logic        small_sign;
    logic [7:0]  large_e;
    logic [4:0]  shift_n;
    logic        special;
    logic [31:0] special_res;

    int n_checks = 0;
    int n_errors = 0;

    fpadd_align_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .large_mant  (large_mant),
        .small_mant  (small_mant),
        .large_sign  (large_sign),
        .small_sign  (small_sign),
        .large_e     (large_e),
        .shift_n     (shift_n),
        .special     (special),
        .special_res (special_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Single transaction with out_ready high; returns at the negedge after acceptance.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        a         = ia;
        b         = ib;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] got_e [0:7];
    int         n_got;
    logic       acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_large_mant", {8'd0, large_mant}, 32'd0);
        rst_n = 1'b1;

        // 1.0 + 2.0
        do_op(32'h3F80_0000, 32'h4000_0000);
        check("t1_valid",      {31'd0, out_valid},  32'd1);
        check("t1_large_mant", {8'd0, large_mant},  32'h0080_0000);
        check("t1_small_mant", {8'd0, small_mant},  32'h0080_0000);
        check("t1_large_e",    {24'd0, large_e},    32'h80);
        check("t1_shift",      {27'd0, shift_n},    32'd1);
        check("t1_special",    {31'd0, special},    32'd0);
        check("t1_res",        special_res,         32'd0);

        // Denormals, b larger magnitude
        do_op(32'h0000_0001, 32'h8000_0003);
        check("t2_large_sign", {31'd0, large_sign}, 32'd1);
        check("t2_small_sign", {31'd0, small_sign}, 32'd0);
        check("t2_large_mant", {8'd0, large_mant},  32'h0000_0003);
        check("t2_small_mant", {8'd0, small_mant},  32'h0000_0001);
        check("t2_large_e",    {24'd0, large_e},    32'h01);
        check("t2_shift",      {27'd0, shift_n},    32'd0);
        check("t2_special",    {31'd0, special},    32'd0);

        // +inf + -inf
        do_op(32'h7F80_0000, 32'hFF80_0000);
        check("t3_special",    {31'd0, special},    32'd1);
        check("t3_res",        special_res,         32'h7FC0_0000);
        check("t3_large_sign", {31'd0, large_sign}, 32'd0);
        check("t3_large_e",    {24'd0, large_e},    32'hFF);

        // -0 + -0
        do_op(32'h8000_0000, 32'h8000_0000);
        check("t4_res",        special_res,         32'h8000_0000);
        check("t4_special",    {31'd0, special},    32'd1);

        // +0 + -0 -> +0
        do_op(32'h0000_0000, 32'h8000_0000);
        check("t4b_res",       special_res,         32'h0000_0000);
        check("t4b_special",   {31'd0, special},    32'd1);

        // Exponent gap 47 saturates
        do_op(32'h4B00_0000, 32'h3380_0000);
        check("t5_shift",      {27'd0, shift_n},    32'd27);
        check("t5_large_e",    {24'd0, large_e},    32'h96);
        check("t5_special",    {31'd0, special},    32'd0);

        // sNaN input
        do_op(32'h7FA0_0000, 32'h3F80_0000);
        check("t6_res",        special_res,         32'h7FC0_0000);

        // inf + finite
        do_op(32'h3F80_0000, 32'hFF80_0000);
        check("t7_res",        special_res,         32'hFF80_0000);

        // zero + denormal
        do_op(32'h0000_0000, 32'h8000_0005);
        check("t8_res",        special_res,         32'h8000_0005);

        // Equal magnitude, opposite signs: a stays large
        do_op(32'h3F80_0000, 32'hBF80_0000);
        check("t9_large_sign", {31'd0, large_sign}, 32'd0);
        check("t9_small_sign", {31'd0, small_sign}, 32'd1);
        check("t9_special",    {31'd0, special},    32'd0);

        // Drain, then backpressure: three back-to-back ops with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        a = 32'h3F80_0000; b = 32'h3F80_0000; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 32'h4000_0000;
        @(negedge clk);
        check("bp_rdy_after1", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 a = 32'h4080_0000;
        @(negedge clk);
        check("bp_rdy_after2", {31'd0, in_ready}, 32'd0);
        check("bp_hold_e",     {24'd0, large_e},  32'h7F);
        @(negedge clk);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_e2",    {24'd0, large_e},   32'h7F);
        check("bp_rdy_held",   {31'd0, in_ready},  32'd0);
        out_ready = 1'b1;
        n_got = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready && n_got < 8) begin
                got_e[n_got] = large_e;
                n_got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1 if (acc) in_valid = 1'b0;
            @(negedge clk);
        end
        check("bp_count", n_got, 32'd3);
        check("bp_e0", {24'd0, got_e[0]}, 32'h7F);
        check("bp_e1", {24'd0, got_e[1]}, 32'h80);
        check("bp_e2", {24'd0, got_e[2]}, 32'h81);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with output and skid both full
        out_ready = 1'b0;
        a = 32'h4000_0000; b = 32'h3F80_0000; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("rr_pre_valid", {31'd0, out_valid}, 32'd1);
        check("rr_pre_rdy",   {31'd0, in_ready},  32'd0);
        rst_n = 1'b0;
        #1;
        check("rr_valid",      {31'd0, out_valid}, 32'd0);
        check("rr_rdy",        {31'd0, in_ready},  32'd1);
        check("rr_large_mant", {8'd0, large_mant}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_got = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) n_got++;
        end
        check("rr_no_stale", n_got, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
